// File: rtl/sample_uart_tx.sv
// sample_uart_tx
//   Buffers averaged ADC samples captured during the SAMPLE system state and
//   sends them out as framed 8N1 bytes once the system enters the UART state.
//   Each sample frame is HEADER, sample[15:8], sample[7:0]. When the macro
//   SAMPLE_CKSUM_EN is defined, a fourth checksum byte
//   (HEADER ^ sample[15:8] ^ sample[7:0]) is appended.
//
// Parameters
//   CLK_FREQ  clock frequency in Hz
//   BAUD      UART bit rate (bit period = CLK_FREQ/BAUD cycles)
//   DEPTH     sample buffer entries (power of 2, >= 2)
//   HEADER    first byte of every sample frame
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   system_state  IDLE=00, SAMPLE=01, COMPLETE=10, UART=11
//   ain_ave       averaged sample, valid while sample_end is high
//   sample_end    level flag; its rising edge captures ain_ave
//   tx            registered serial output, idle high
//   tx_busy       high while a sample stream is on the line
//   uart_done     high once every buffered sample has been sent
//   overflow      sticky; a capture was dropped on a full buffer
//   sample_cnt    number of buffered samples
module sample_uart_tx #(
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         BAUD     = 115200,
    parameter int         DEPTH    = 8,
    parameter logic [7:0] HEADER   = 8'hAA,
    localparam int        CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       system_state,
    input  logic [15:0]      ain_ave,
    input  logic             sample_end,
    output logic             tx,
    output logic             tx_busy,
    output logic             uart_done,
    output logic             overflow,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BAUD_W   = $clog2(BAUD_DIV);
    localparam int PTR_W    = $clog2(DEPTH);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

`ifdef SAMPLE_CKSUM_EN
    localparam logic [1:0] LAST_BYTE = 2'd3;
`else
    localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

    // System states this block reacts to (COMPLETE only matters as "not UART").
    localparam logic [1:0] SYS_IDLE   = 2'b00;
    localparam logic [1:0] SYS_SAMPLE = 2'b01;
    localparam logic [1:0] SYS_UART   = 2'b11;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        state;
    logic              sample_end_d;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [1:0]        byte_idx;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [15:0]       sample_buf [DEPTH];

    logic        capture;
    logic        wr_en;
    logic        baud_tick;
    logic [15:0] cur_sample;
    logic [7:0]  load_byte;

    assign capture    = sample_end && !sample_end_d;
    assign wr_en      = capture && (system_state == SYS_SAMPLE) && (sample_cnt < CNT_FULL);
    assign baud_tick  = (baud_cnt == BAUD_LAST);
    assign cur_sample = sample_buf[rd_ptr];

    always_comb begin
        load_byte = HEADER;
        case (byte_idx)
            2'd1:    load_byte = cur_sample[15:8];
            2'd2:    load_byte = cur_sample[7:0];
`ifdef SAMPLE_CKSUM_EN
            2'd3:    load_byte = HEADER ^ cur_sample[15:8] ^ cur_sample[7:0];
`endif
            default: load_byte = HEADER;
        endcase
    end

    // Buffer storage carries no reset; validity is tracked by sample_cnt.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            sample_buf[wr_ptr] <= ain_ave;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            sample_end_d <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sample_cnt   <= '0;
            overflow     <= 1'b0;
            byte_idx     <= '0;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            uart_done    <= 1'b0;
        end else begin
            sample_end_d <= sample_end;
            // Registered from the state so it rises together with tx_busy falling.
            uart_done    <= (state == S_DONE);

            if (system_state == SYS_IDLE) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                sample_cnt <= '0;
                overflow   <= 1'b0;
                state      <= S_IDLE;
                byte_idx   <= '0;
                baud_cnt   <= '0;
                bit_cnt    <= '0;
                tx         <= 1'b1;
                tx_busy    <= 1'b0;
                uart_done  <= 1'b0;
            end else begin
                if (capture && (system_state == SYS_SAMPLE)) begin
                    if (sample_cnt < CNT_FULL) begin
                        wr_ptr     <= wr_ptr + PTR_ONE;
                        sample_cnt <= sample_cnt + CNT_ONE;
                    end else begin
                        overflow <= 1'b1;
                    end
                end

                case (state)
                    S_IDLE: begin
                        tx       <= 1'b1;
                        tx_busy  <= 1'b0;
                        byte_idx <= '0;
                        if (system_state == SYS_UART) begin
                            state <= (sample_cnt != '0) ? S_LOAD : S_DONE;
                        end
                    end
                    S_LOAD: begin
                        shreg    <= load_byte;
                        tx       <= 1'b0;
                        tx_busy  <= 1'b1;
                        baud_cnt <= '0;
                        state    <= S_START;
                    end
                    // tx is registered, so each state presents the next bit on
                    // its final baud tick; shreg[0] always holds the next bit.
                    S_START: begin
                        if (baud_tick) begin
                            baud_cnt <= '0;
                            tx       <= shreg[0];
                            shreg    <= {1'b0, shreg[7:1]};
                            bit_cnt  <= '0;
                            state    <= S_DATA;
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_ONE;
                        end
                    end
                    S_DATA: begin
                        if (baud_tick) begin
                            baud_cnt <= '0;
                            if (bit_cnt == 3'd7) begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end else begin
                                tx      <= shreg[0];
                                shreg   <= {1'b0, shreg[7:1]};
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_ONE;
                        end
                    end
                    S_STOP: begin
                        if (baud_tick) begin
                            baud_cnt <= '0;
                            if (system_state != SYS_UART) begin
                                state <= S_IDLE;
                            end else if (byte_idx != LAST_BYTE) begin
                                byte_idx <= byte_idx + 2'd1;
                                state    <= S_LOAD;
                            end else if (sample_cnt > CNT_ONE) begin
                                rd_ptr     <= rd_ptr + PTR_ONE;
                                sample_cnt <= sample_cnt - CNT_ONE;
                                byte_idx   <= '0;
                                state      <= S_LOAD;
                            end else begin
                                sample_cnt <= sample_cnt - CNT_ONE;
                                state      <= S_DONE;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_ONE;
                        end
                    end
                    S_DONE: begin
                        tx_busy <= 1'b0;
                        if (system_state != SYS_UART) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_uart_tx.sv
module tb_sample_uart_tx;

    localparam int BD       = 50_000_000 / 115200;
    localparam int DEPTH    = 8;
    localparam int BYTE_CYC = 10 * BD;
`ifdef SAMPLE_CKSUM_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif

    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_SAMPLE   = 2'b01;
    localparam logic [1:0] ST_COMPLETE = 2'b10;
    localparam logic [1:0] ST_UART     = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  system_state;
    logic [15:0] ain_ave;
    logic        sample_end;
    logic        tx;
    logic        tx_busy;
    logic        uart_done;
    logic        overflow;
    logic [3:0]  sample_cnt;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    logic [15:0] model_q[$];
    logic        model_ovf;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    int unsigned rx_start_q[$];

    sample_uart_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .system_state (system_state),
        .ain_ave      (ain_ave),
        .sample_end   (sample_end),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .uart_done    (uart_done),
        .overflow     (overflow),
        .sample_cnt   (sample_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] frame_byte(input logic [15:0] s, input int k);
        case (k)
            0:       return 8'hAA;
            1:       return s[15:8];
            2:       return s[7:0];
            default: return 8'hAA ^ s[15:8] ^ s[7:0];
        endcase
    endfunction

    // Reference: a capture adds one sample if room remains, else flags overflow.
    task automatic pulse(input logic [15:0] v, input int unsigned hold);
        ain_ave    = v;
        sample_end = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        sample_end = 1'b0;
        ain_ave    = 16'($urandom);
        repeat ($urandom_range(4, 2)) @(posedge clk);
        #1;
        if (system_state == ST_SAMPLE) begin
            if (model_q.size() < DEPTH) model_q.push_back(v);
            else model_ovf = 1'b1;
        end
        check("cap_cnt", 32'(sample_cnt), 32'(model_q.size()));
    endtask

    task automatic goto_idle();
        system_state = ST_IDLE;
        repeat (2) @(posedge clk);
        #1;
        model_q.delete();
        model_ovf = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int unsigned budget);
        for (int unsigned t = 0; t < budget && rx_q.size() < n; t++) @(negedge clk);
    endtask

    // Line receiver: detects start bit, samples each bit mid-period.
    initial begin : rx_mon
        logic [7:0]  b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                rx_start_q.push_back(cyc);
                repeat (BD / 2) @(negedge clk);
                check("rx_start_bit", 32'(tx), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BD) @(negedge clk);
                check("rx_stop_bit", 32'(tx), 32'd1);
                rx_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        repeat (150_000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin : stim
        int unsigned c0;
        int unsigned ls;
        int          n;
        int          low_cnt;
        int          done_cnt;

        // Reset with sample_end held high
        rst_n        = 1'b0;
        system_state = ST_IDLE;
        ain_ave      = 16'h5555;
        sample_end   = 1'b1;
        model_ovf    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_uart_done", 32'(uart_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_cnt", 32'(sample_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_cnt", 32'(sample_cnt), 32'd0);
        sample_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Three held pulses, one capture each
        system_state = ST_SAMPLE;
        @(posedge clk);
        #1;
        pulse(16'h0123, 5);
        pulse(16'h0ABC, 5);
        pulse(16'h0FFF, 5);
        check("s2_cnt", 32'(sample_cnt), 32'd3);
        check("s2_overflow", 32'(overflow), 32'd0);

        // Full transmission
        exp_q.delete();
        foreach (model_q[i]) for (int k = 0; k < FRAME_LEN; k++) exp_q.push_back(frame_byte(model_q[i], k));
        n = exp_q.size();
        rx_q.delete();
        rx_start_q.delete();
        system_state = ST_COMPLETE;
        @(posedge clk);
        #1;
        system_state = ST_UART;
        c0 = cyc;
        wait_bytes(n, n * (BYTE_CYC + 1) + 100);
        check("s3_nbytes", 32'(rx_q.size()), 32'(n));
        for (int k = 0; k < n && k < rx_q.size(); k++) check("s3_byte", 32'(rx_q[k]), 32'(exp_q[k]));
        if (rx_start_q.size() > 0) check("s3_first_start", rx_start_q[0] - c0, 32'd2);
        for (int k = 1; k < rx_start_q.size(); k++)
            check("s3_byte_period", rx_start_q[k] - rx_start_q[k-1], 32'(BYTE_CYC + 1));
        if (rx_start_q.size() == n) begin
            ls = rx_start_q[n-1];
            while (cyc < ls + BYTE_CYC) @(negedge clk);
            check("s3_done_before", 32'(uart_done), 32'd0);
            check("s3_busy_before", 32'(tx_busy), 32'd1);
            @(negedge clk);
            check("s3_done", 32'(uart_done), 32'd1);
            check("s3_busy_after", 32'(tx_busy), 32'd0);
            check("s3_cnt_after", 32'(sample_cnt), 32'd0);
            check("s3_tx_idle", 32'(tx), 32'd1);
        end
        model_q.delete();

        // Overflow: nine random captures into an 8-deep buffer
        goto_idle();
        check("s5_clear_cnt", 32'(sample_cnt), 32'd0);
        system_state = ST_SAMPLE;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) pulse(16'($urandom), $urandom_range(6, 1));
        check("s5_full_no_ovf", 32'(overflow), 32'd0);
        pulse(16'($urandom), $urandom_range(6, 1));
        check("s5_cnt", 32'(sample_cnt), 32'd8);
        check("s5_overflow", 32'(overflow), 32'(model_ovf));

        // Abort halfway through the second byte
        rx_q.delete();
        rx_start_q.delete();
        system_state = ST_UART;
        for (int unsigned t = 0; t < 3 * BYTE_CYC && rx_start_q.size() < 2; t++) @(negedge clk);
        check("s6_second_start", 32'(rx_start_q.size()), 32'd2);
        if (rx_start_q.size() == 2) while (cyc < rx_start_q[1] + BYTE_CYC / 2) @(negedge clk);
        @(posedge clk);
        #1;
        system_state = ST_COMPLETE;
        wait_bytes(2, BYTE_CYC);
        check("s6_nbytes", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            check("s6_byte0", 32'(rx_q[0]), 32'(frame_byte(model_q[0], 0)));
            check("s6_byte1", 32'(rx_q[1]), 32'(frame_byte(model_q[0], 1)));
        end
        low_cnt  = 0;
        done_cnt = 0;
        repeat (BYTE_CYC + 2 * BD) begin
            @(negedge clk);
            if (tx !== 1'b1) low_cnt++;
            if (uart_done !== 1'b0) done_cnt++;
        end
        check("s6_tx_quiet", 32'(low_cnt), 32'd0);
        check("s6_no_done", 32'(done_cnt), 32'd0);
        check("s6_no_more_bytes", 32'(rx_q.size()), 32'd2);
        check("s6_cnt_kept", 32'(sample_cnt), 32'(model_q.size()));
        check("s6_busy", 32'(tx_busy), 32'd0);

        goto_idle();
        check("s6_idle_ovf", 32'(overflow), 32'd0);
        check("s6_idle_cnt", 32'(sample_cnt), 32'd0);

        // Empty buffer: done two cycles after entering UART
        @(posedge clk);
        #1;
        system_state = ST_UART;
        @(posedge clk);
        #1;
        check("empty_done_c1", 32'(uart_done), 32'd0);
        @(posedge clk);
        #1;
        check("empty_done_c2", 32'(uart_done), 32'd1);
        check("empty_tx", 32'(tx), 32'd1);

        // Asynchronous reset in the middle of a byte
        goto_idle();
        system_state = ST_SAMPLE;
        @(posedge clk);
        #1;
        pulse(16'($urandom), 2);
        pulse(16'($urandom), 3);
        system_state = ST_UART;
        repeat (1000) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx), 32'd1);
        check("async_rst_cnt", 32'(sample_cnt), 32'd0);
        check("async_rst_busy", 32'(tx_busy), 32'd0);
        system_state = ST_IDLE;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (BYTE_CYC) @(posedge clk);
        #1;
        check("post_rst_tx", 32'(tx), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
